posit_stream_checker: RTL and testbench
=======================================

// Module: posit_stream_checker
// PURPOSE
//   Synthesisable checker that grades a pipelined posit arithmetic unit against golden results.
//   It carries each golden value through a LATENCY-deep delay line, aligned with the DUT pipeline.
//   Each sample gets a posit-ordered absolute difference and a tolerance check.
//   Counters and sticky flags are kept for on-chip and regression use; sits beside positadd_*/positmul_* in the datapath.
// PARAMETERS
//   N        32  posit word width (bits)
//   LATENCY  4   DUT latency in cycles, issue->result; legal range 1..64
//   TOL      0   max allowed |diff| (in ULP pattern units) before a sample counts as mismatch
//   CNT_W    32  width of sample/error counters and sample index
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high reset
//   clear         in   1      synchronous soft clear of counters/sticky flags (pipeline untouched)
//   in_valid      in   1      operands issued to DUT this cycle; expected is valid
//   expected      in   N      golden result for the operands issued this cycle
//   dut_result    in   N      DUT result output
//   dut_done      in   1      DUT done/valid output
//   chk_valid     out  1      diff/mismatch/chk_index valid this cycle
//   diff          out  N      |signed(expected) - signed(dut_result)|, unsigned
//   mismatch      out  1      diff > TOL for this sample
//   chk_index     out  CNT_W  issue index of the graded sample
//   sample_count  out  CNT_W  samples graded since reset/clear, saturating
//   err_count     out  CNT_W  mismatching samples since reset/clear, saturating
//   max_diff      out  N      largest diff seen since reset/clear
//   latency_err   out  1      sticky: dut_done disagreed with delayed in_valid
// BEHAVIOUR
//   - Reset: all outputs 0; delay-line valid bits and issue index counter 0; in-flight samples dropped.
//   - Issue: in_valid=1 at cycle t pushes {1, expected, issue_idx}; issue_idx then increments (wraps at 2^CNT_W).
//   - in_valid=0 pushes a bubble. The delay line shifts every cycle; there is no stall and no backpressure.
//   - Check stage at t+LATENCY: compares the stage entry with dut_result/dut_done sampled that cycle.
//   - Outputs are registered: chk_valid/diff/mismatch/chk_index appear at t+LATENCY+1 for one cycle.
//   - diff: operands are sign-extended to N+1 bits, giving two's-complement (posit) ordering.
//     Subtract, take the absolute value, keep the low N bits (the result always fits).
//     diff is held when chk_valid=0.
//   - mismatch = chk_valid & (diff > TOL); it is 0 when chk_valid=0.
//   - Counters: sample_count += 1 per graded sample; err_count += 1 per mismatch. Both saturate at all-ones, no wrap.
//   - max_diff <= max(max_diff, diff) on each graded sample.
//   - latency_err: set when the check-stage valid != dut_done. Sticky until reset/clear.
//     The sample is still graded when the check-stage valid is 1.
//   - clear: zeroes sample_count, err_count, max_diff, latency_err in the next cycle.
//     A sample graded in the clear cycle still drives chk_valid/diff/mismatch but is NOT counted.
//   - Reset mid-stream: any sample issued <= LATENCY cycles before reset deasserts is never graded.
//   - Back-to-back issue at full rate (in_valid every cycle) is supported; one sample graded per cycle.
// CONFIGURATION
//   POSIT_CHK_NAR_EN defined: NaR (1 followed by N-1 zeros) is handled specially.
//     - If exactly one of expected/dut_result is NaR: diff = all-ones, mismatch = 1 regardless of TOL.
//     - If both are NaR: diff = 0, mismatch = 0.
//   POSIT_CHK_NAR_EN undefined: NaR is an ordinary pattern, i.e. the most negative integer in the diff arithmetic.
// TESTING
//   1 LATENCY=4, TOL=0; in_valid=1 for 8 cycles, dut_result==expected aligned by 4 cycles, dut_done aligned
//     -> chk_valid at cycles 5..12, diff=0, chk_index 0..7, sample_count=8, err_count=0, latency_err=0
//   2 expected=32'h40000000, dut_result=32'h40000003; TOL=0 then TOL=3
//     -> diff=3; mismatch=1/err_count=1 with TOL=0; mismatch=0 with TOL=3; max_diff=3
//   3 expected=32'h00000001, dut_result=32'hFFFFFFFF (posit neg)
//     -> diff=2 (signed ordering, not 32'hFFFFFFFE)
//   4 dut_done asserted one cycle late relative to in_valid
//     -> latency_err rises on first skew cycle and stays 1; clear pulse -> latency_err=0, counters 0
//   5 POSIT_CHK_NAR_EN: expected=32'h80000000, dut_result=32'h00000000
//     -> diff=32'hFFFFFFFF, mismatch=1; both NaR -> diff=0, mismatch=0
//     Without the macro: diff=32'h80000000
//   6 Continuous stream; reset asserted 2 cycles after last issue, then released
//     -> no chk_valid for dropped samples, all counters 0, next issue gets chk_index=0

Source files
------------

// File: rtl/posit_stream_checker.sv
// Grades a pipelined posit unit: delays golden values by LATENCY cycles and compares with the DUT result.
// Optional NaR-aware grading is enabled by defining POSIT_CHK_NAR_EN.
module posit_stream_checker #(
    parameter int N       = 32,
    parameter int LATENCY = 4,
    parameter int TOL     = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [N-1:0]     expected,
    input  logic [N-1:0]     dut_result,
    input  logic             dut_done,
    output logic             chk_valid,
    output logic [N-1:0]     diff,
    output logic             mismatch,
    output logic [CNT_W-1:0] chk_index,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [N-1:0]     max_diff,
    output logic             latency_err
);

    localparam logic [N-1:0] TOL_V = N'(TOL);
`ifdef POSIT_CHK_NAR_EN
    localparam logic [N-1:0] NAR   = {1'b1, {(N-1){1'b0}}};
`endif

    logic             pv [LATENCY];
    logic [N-1:0]     pe [LATENCY];
    logic [CNT_W-1:0] pi [LATENCY];
    logic [CNT_W-1:0] issue_idx;

    // Valid bits and the issue counter are reset; the payload is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                pv[k] <= 1'b0;
            end
            issue_idx <= '0;
        end else begin
            pv[0] <= in_valid;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                pv[k] <= pv[k-1];
            end
            if (in_valid) begin
                issue_idx <= issue_idx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        pe[0] <= expected;
        pi[0] <= issue_idx;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            pe[k] <= pe[k-1];
            pi[k] <= pi[k-1];
        end
    end

    logic             chk_v;
    logic [N-1:0]     chk_e;
    logic [CNT_W-1:0] chk_i;
    logic [N:0]       sub;
    logic [N:0]       neg;
    logic [N-1:0]     diff_c;
    logic             mm_c;

    assign chk_v = pv[LATENCY-1];
    assign chk_e = pe[LATENCY-1];
    assign chk_i = pi[LATENCY-1];

    // N+1-bit signed subtraction; the magnitude never exceeds 2^N-1 so the low N bits suffice.
    always_comb begin
        sub    = {chk_e[N-1], chk_e} - {dut_result[N-1], dut_result};
        neg    = '0 - sub;
        diff_c = sub[N] ? neg[N-1:0] : sub[N-1:0];
        mm_c   = (diff_c > TOL_V);
`ifdef POSIT_CHK_NAR_EN
        if ((chk_e == NAR) && (dut_result == NAR)) begin
            diff_c = '0;
            mm_c   = 1'b0;
        end else if ((chk_e == NAR) != (dut_result == NAR)) begin
            diff_c = '1;
            mm_c   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_valid    <= 1'b0;
            diff         <= '0;
            mismatch     <= 1'b0;
            chk_index    <= '0;
            sample_count <= '0;
            err_count    <= '0;
            max_diff     <= '0;
            latency_err  <= 1'b0;
        end else begin
            chk_valid <= chk_v;
            mismatch  <= chk_v & mm_c;
            if (chk_v) begin
                diff      <= diff_c;
                chk_index <= chk_i;
            end
            // Clear wins over accumulation: a sample graded this cycle is reported but not counted.
            if (clear) begin
                sample_count <= '0;
                err_count    <= '0;
                max_diff     <= '0;
                latency_err  <= 1'b0;
            end else begin
                if (chk_v) begin
                    if (sample_count != '1) begin
                        sample_count <= sample_count + CNT_W'(1);
                    end
                    if (mm_c && (err_count != '1)) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (diff_c > max_diff) begin
                        max_diff <= diff_c;
                    end
                end
                if (chk_v != dut_done) begin
                    latency_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Randomized and directed bench for posit_stream_checker against a queue-based reference model.
module tb_posit_stream_checker;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, dut_done;
    logic [31:0] expected, dut_result;

    logic        o0_cv, o0_mm, o0_lat;
    logic [31:0] o0_diff, o0_idx, o0_sc, o0_ec, o0_max;
    logic        o3_cv, o3_mm, o3_lat;
    logic [31:0] o3_diff, o3_idx, o3_sc, o3_ec, o3_max;
    logic        o2_cv, o2_mm, o2_lat;
    logic [31:0] o2_diff, o2_max;
    logic [3:0]  o2_idx, o2_sc, o2_ec;

    always #5 clk = ~clk;

    posit_stream_checker #(.N(32), .LATENCY(L), .TOL(0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .expected(expected),
        .dut_result(dut_result), .dut_done(dut_done), .chk_valid(o0_cv), .diff(o0_diff),
        .mismatch(o0_mm), .chk_index(o0_idx), .sample_count(o0_sc), .err_count(o0_ec),
        .max_diff(o0_max), .latency_err(o0_lat));

    posit_stream_checker #(.N(32), .LATENCY(L), .TOL(3), .CNT_W(32)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .expected(expected),
        .dut_result(dut_result), .dut_done(dut_done), .chk_valid(o3_cv), .diff(o3_diff),
        .mismatch(o3_mm), .chk_index(o3_idx), .sample_count(o3_sc), .err_count(o3_ec),
        .max_diff(o3_max), .latency_err(o3_lat));

    posit_stream_checker #(.N(32), .LATENCY(L), .TOL(0), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .expected(expected),
        .dut_result(dut_result), .dut_done(dut_done), .chk_valid(o2_cv), .diff(o2_diff),
        .mismatch(o2_mm), .chk_index(o2_idx), .sample_count(o2_sc), .err_count(o2_ec),
        .max_diff(o2_max), .latency_err(o2_lat));

    typedef struct {
        logic [31:0] e;
        logic [31:0] r;
        int unsigned idx;
        int unsigned due;
    } ent_t;

    ent_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned next_idx = 0;
    bit          prev_due = 0;
    bit          g_skew = 0;

    bit          m_cv, m_mm0, m_mm3, m_lat;
    logic [31:0] m_diff, m_max;
    int unsigned m_cidx, m_sc, m_ec0, m_ec3;

    function automatic int unsigned sat4(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    // Absolute difference of two posit patterns viewed as signed integers.
    task automatic ref_grade(input logic [31:0] e, input logic [31:0] r, input int tol,
                             output logic [31:0] d_out, output bit mm_out);
        longint a, b, d;
        a = longint'($signed(e));
        b = longint'($signed(r));
        d = a - b;
        if (d < 0) d = -d;
        d_out  = d[31:0];
        mm_out = (d > longint'(tol));
`ifdef POSIT_CHK_NAR_EN
        if (e == 32'h80000000 && r == 32'h80000000) begin
            d_out = 32'h0; mm_out = 0;
        end else if ((e == 32'h80000000) != (r == 32'h80000000)) begin
            d_out = 32'hFFFFFFFF; mm_out = 1;
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit iv, input logic [31:0] e, input logic [31:0] r,
                        input bit clr, input bit rst);
        bit          due_now, done;
        logic [31:0] d;
        bit          mm0, mm3;
        due_now    = (q.size() > 0) && (q[0].due == cyc);
        done       = g_skew ? prev_due : due_now;
        in_valid   = iv;
        expected   = e;
        dut_result = due_now ? q[0].r : $urandom;
        dut_done   = done;
        clear      = clr;
        reset      = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            next_idx = 0;
            {m_cv, m_mm0, m_mm3, m_lat} = '0;
            m_diff = 0; m_max = 0; m_cidx = 0; m_sc = 0; m_ec0 = 0; m_ec3 = 0;
            prev_due = 0;
        end else begin
            m_cv = due_now; m_mm0 = 0; m_mm3 = 0;
            if (due_now) begin
                ref_grade(q[0].e, q[0].r, 0, d, mm0);
                ref_grade(q[0].e, q[0].r, 3, d, mm3);
                m_diff = d; m_mm0 = mm0; m_mm3 = mm3; m_cidx = q[0].idx;
                void'(q.pop_front());
            end
            if (clr) begin
                m_sc = 0; m_ec0 = 0; m_ec3 = 0; m_max = 0; m_lat = 0;
            end else begin
                if (due_now) begin
                    m_sc++;
                    if (m_mm0) m_ec0++;
                    if (m_mm3) m_ec3++;
                    if (m_diff > m_max) m_max = m_diff;
                end
                if (due_now != done) m_lat = 1;
            end
            if (iv) begin
                q.push_back('{e: e, r: r, idx: next_idx, due: cyc + L});
                next_idx++;
            end
            prev_due = due_now;
        end
        cyc++;
        #1;
        chk("chk_valid", {63'd0, o0_cv}, {63'd0, m_cv});
        chk("chk_valid_tol3", {63'd0, o3_cv}, {63'd0, m_cv});
        chk("diff", {32'd0, o0_diff}, {32'd0, m_diff});
        chk("mismatch", {63'd0, o0_mm}, {63'd0, m_mm0});
        chk("mismatch_tol3", {63'd0, o3_mm}, {63'd0, m_mm3});
        if (m_cv) begin
            chk("chk_index", {32'd0, o0_idx}, {32'd0, m_cidx});
            chk("chk_index_w4", {60'd0, o2_idx}, {60'd0, m_cidx[3:0]});
        end
        chk("sample_count", {32'd0, o0_sc}, {32'd0, m_sc});
        chk("err_count", {32'd0, o0_ec}, {32'd0, m_ec0});
        chk("err_count_tol3", {32'd0, o3_ec}, {32'd0, m_ec3});
        chk("sample_count_w4", {60'd0, o2_sc}, 64'(sat4(m_sc)));
        chk("err_count_w4", {60'd0, o2_ec}, 64'(sat4(m_ec0)));
        chk("max_diff", {32'd0, o0_max}, {32'd0, m_max});
        chk("latency_err", {63'd0, o0_lat}, {63'd0, m_lat});
    endtask

    task automatic issue(input logic [31:0] e, input logic [31:0] r);
        step(1'b1, e, r, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] e, r;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            e = $urandom;
            issue(e, e);
        end
        idle(L + 1);
        chk("t1_samples", {32'd0, o0_sc}, 64'd8);
        chk("t1_errors", {32'd0, o0_ec}, 64'd0);
        chk("t1_last_index", {32'd0, o0_idx}, 64'd7);

        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(32'h40000000, 32'h40000003);
        idle(L + 1);
        chk("t2_diff", {32'd0, o0_diff}, 64'd3);
        chk("t2_err_tol0", {32'd0, o0_ec}, 64'd1);
        chk("t2_err_tol3", {32'd0, o3_ec}, 64'd0);
        chk("t2_max", {32'd0, o0_max}, 64'd3);

        issue(32'h00000001, 32'hFFFFFFFF);
        idle(L + 1);
        chk("t3_diff", {32'd0, o0_diff}, 64'd2);

        issue(32'h80000000, 32'h00000000);
        idle(L + 1);
`ifdef POSIT_CHK_NAR_EN
        chk("t5_nar_diff", {32'd0, o0_diff}, 64'hFFFFFFFF);
`else
        chk("t5_nar_diff", {32'd0, o0_diff}, 64'h80000000);
`endif
        issue(32'h80000000, 32'h80000000);
        idle(L + 1);
        chk("t5_both_nar", {32'd0, o0_diff}, 64'd0);

        for (int i = 0; i < 80; i++) begin
            e = $urandom;
            case ($urandom_range(0, 4))
                0: r = e;
                1: r = e + 32'($urandom_range(0, 8)) - 32'd4;
                2: r = $urandom;
                3: r = 32'h80000000;
                default: begin e = 32'h80000000; r = e + 32'($urandom_range(0, 1)); end
            endcase
            if ($urandom_range(0, 3) != 0) issue(e, r);
            else step(1'b0, e, 32'h0, ($urandom_range(0, 5) == 0), 1'b0);
        end
        idle(L + 1);

        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            e = $urandom;
            issue(e, e + 32'd1);
        end
        idle(L + 1);
        chk("sat_samples_w4", {60'd0, o2_sc}, 64'd15);
        chk("sat_errors_w4", {60'd0, o2_ec}, 64'd15);

        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        g_skew = 1;
        for (int i = 0; i < 3; i++) begin
            e = $urandom;
            issue(e, e);
        end
        idle(L + 2);
        g_skew = 0;
        chk("t4_latency_sticky", {63'd0, o0_lat}, 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t4_cleared_lat", {63'd0, o0_lat}, 64'd0);
        chk("t4_cleared_count", {32'd0, o0_sc}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            e = $urandom;
            issue(e, e);
        end
        idle(2);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(L + 2);
        e = $urandom;
        issue(e, e);
        idle(L + 1);
        chk("t6_index", {32'd0, o0_idx}, 64'd0);
        chk("t6_count", {32'd0, o0_sc}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
